// File: rtl/uart_pkg.sv
// Shared UART constants: data width and receive-FIFO default geometry.
package uart_pkg;
  localparam int UART_DATA_W            = 8;
  localparam int UART_RX_FIFO_DEPTH_DEF = 16;
  localparam int UART_RX_FIFO_AF_DEF    = 12;
endpackage

// File: rtl/uart_fifo_ram.sv
// DEPTH x 8 storage: one synchronous write port, one asynchronous read port, no reset.
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RX_FIFO_DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   i_clock,
  input  logic                   i_we,
  input  logic [AW-1:0]          i_waddr,
  input  logic [UART_DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]          i_raddr,
  output logic [UART_DATA_W-1:0] o_rdata
);
  logic [UART_DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO behind a UART receiver with sticky overrun flag.
// Define UART_RX_FIFO_STATS_EN to add accepted/dropped byte counters.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH     = UART_RX_FIFO_DEPTH_DEF,
  parameter int AF_THRESH = UART_RX_FIFO_AF_DEF
) (
  input  logic                     i_clock,
  input  logic                     i_rst_n,
  input  logic [UART_DATA_W-1:0]   i_rx_byte,
  input  logic                     i_rx_done,
  output logic [UART_DATA_W-1:0]   o_rd_data,
  output logic                     o_rd_valid,
  input  logic                     i_rd_ready,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_almost_full,
  output logic                     o_overrun,
  input  logic                     i_clr_overrun
`ifdef UART_RX_FIFO_STATS_EN
  ,
  output logic [15:0]              o_rx_count,
  output logic [15:0]              o_drop_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] AF_LVL   = LW'(AF_THRESH);

  logic [AW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_level;
  logic          r_overrun;
  logic          w_full, w_empty, w_rd, w_wr, w_drop;

  assign w_full  = (r_level == FULL_LVL);
  assign w_empty = (r_level == '0);
  // A read frees a slot in the same edge, so a full FIFO still accepts a write alongside it.
  assign w_rd    = !w_empty && i_rd_ready;
  assign w_wr    = i_rx_done && (!w_full || w_rd);
  assign w_drop  = i_rx_done && !w_wr;

  uart_fifo_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .i_clock (i_clock),
    .i_we    (w_wr),
    .i_waddr (r_wptr),
    .i_wdata (i_rx_byte),
    .i_raddr (r_rptr),
    .o_rdata (o_rd_data)
  );

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      // Drop takes priority so a coincident clear cannot hide a fresh loss.
      if (w_drop)             r_overrun <= 1'b1;
      else if (i_clr_overrun) r_overrun <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_STATS_EN
  logic [15:0] r_rx_count, r_drop_count;

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_count   <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_wr)   r_rx_count   <= r_rx_count + 16'd1;
      if (w_drop) r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign o_rx_count   = r_rx_count;
  assign o_drop_count = r_drop_count;
`endif

  assign o_level       = r_level;
  assign o_full        = w_full;
  assign o_empty       = w_empty;
  assign o_almost_full = (r_level >= AF_LVL);
  assign o_rd_valid    = !w_empty;
  assign o_overrun     = r_overrun;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_byte = '0;
  logic          rx_done = 1'b0;
  logic          rd_ready = 1'b0;
  logic          clr_ovr = 1'b0;
  logic [7:0]    rd_data;
  logic          rd_valid, full, empty, afull, ovr;
  logic [LW-1:0] level;
`ifdef UART_RX_FIFO_STATS_EN
  logic [15:0]   rx_cnt, drop_cnt;
`endif

  // reference model
  logic [7:0]  q[$];
  logic        m_ovr;
  logic [15:0] m_rx, m_drop;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(DEPTH), .AF_THRESH(AF)) dut (
    .i_clock       (clk),
    .i_rst_n       (rst_n),
    .i_rx_byte     (rx_byte),
    .i_rx_done     (rx_done),
    .o_rd_data     (rd_data),
    .o_rd_valid    (rd_valid),
    .i_rd_ready    (rd_ready),
    .o_level       (level),
    .o_full        (full),
    .o_empty       (empty),
    .o_almost_full (afull),
    .o_overrun     (ovr),
    .i_clr_overrun (clr_ovr)
`ifdef UART_RX_FIFO_STATS_EN
    ,
    .o_rx_count    (rx_cnt),
    .o_drop_count  (drop_cnt)
`endif
  );

  task automatic model_clear();
    q.delete();
    m_ovr  = 1'b0;
    m_rx   = '0;
    m_drop = '0;
  endtask

  // One clock: drive inputs, take the edge, advance the model, return 1 time unit after the edge.
  task automatic cyc(input logic d, input logic [7:0] b, input logic rdy, input logic clr);
    bit rd, wr;
    rx_done = d; rx_byte = b; rd_ready = rdy; clr_ovr = clr;
    rd = (q.size() != 0) && rdy;
    wr = d && ((q.size() < DEPTH) || rd);
    @(posedge clk);
    if (rd) void'(q.pop_front());
    if (wr) begin q.push_back(b); m_rx++; end
    if (d && !wr) begin m_ovr = 1'b1; m_drop++; end
    else if (clr) m_ovr = 1'b0;
    #1;
    rx_done = 1'b0; rd_ready = 1'b0; clr_ovr = 1'b0;
  endtask

  task automatic test_reset();
    model_clear();
    rst_n = 1'b0;
    #12;
    n_tests++;
    if ({empty, rd_valid, full, afull, ovr} !== 5'b10000 || level !== '0) begin
      n_fail++;
      $display("FAIL reset_state: empty/valid/full/af/ovr=%b level=%0d, need 10000 level 0",
               {empty, rd_valid, full, afull, ovr}, level);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_single();
    cyc(1, 8'h55, 0, 0);
    n_tests++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h55 || level !== LW'(1) || empty !== 1'b0) begin
      n_fail++;
      $display("FAIL single_write: valid=%b data=%h level=%0d empty=%b, need 1 55 1 0",
               rd_valid, rd_data, level, empty);
    end
    cyc(0, 0, 1, 0);
    n_tests++;
    if (empty !== 1'b1 || level !== '0) begin
      n_fail++;
      $display("FAIL single_drain: empty=%b level=%0d, need 1 0", empty, level);
    end
  endtask

  task automatic test_fill_overrun();
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, 8'(i), 0, 0);
      n_tests++;
      if (afull !== ((i + 1) >= AF) || full !== ((i + 1) == DEPTH) || level !== LW'(i + 1)) begin
        n_fail++;
        $display("FAIL fill_flags[%0d]: af=%b full=%b level=%0d, need af=%b full=%b level=%0d",
                 i, afull, full, level, (i + 1) >= AF, (i + 1) == DEPTH, i + 1);
      end
    end
    cyc(1, 8'hAA, 0, 0);
    n_tests++;
    if (ovr !== 1'b1 || level !== LW'(DEPTH) || full !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_drop: ovr=%b level=%0d full=%b, need 1 %0d 1", ovr, level, full, DEPTH);
    end
    cyc(0, 0, 0, 1);
    n_tests++;
    if (ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clear: ovr=%b, need 0", ovr);
    end
    // full FIFO, write and read together
    n_tests++;
    if (rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL full_head: data=%h, need 00", rd_data);
    end
    cyc(1, 8'h77, 1, 0);
    n_tests++;
    if (level !== LW'(DEPTH) || ovr !== 1'b0 || rd_data !== 8'h01) begin
      n_fail++;
      $display("FAIL full_rw: level=%0d ovr=%b data=%h, need %0d 0 01", level, ovr, rd_data, DEPTH);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      n_tests++;
      if (rd_valid !== 1'b1 || rd_data !== ((i == DEPTH) ? 8'h77 : 8'(i))) begin
        n_fail++;
        $display("FAIL drain_order[%0d]: valid=%b data=%h, need 1 %h",
                 i, rd_valid, rd_data, (i == DEPTH) ? 8'h77 : 8'(i));
      end
      cyc(0, 0, 1, 0);
    end
    n_tests++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_empty: empty=%b, need 1", empty);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] b;
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom);
      cyc(1, b, 1, 0);
      n_tests++;
      if (level !== LW'(q.size()) || rd_valid !== 1'b1 || rd_data !== q[0]) begin
        n_fail++;
        $display("FAIL wrap[%0d]: level=%0d data=%h, need %0d %h", i, level, rd_data, q.size(), q[0]);
      end
    end
    cyc(0, 0, 1, 0);
    n_tests++;
    if (empty !== 1'b1 || level !== '0) begin
      n_fail++;
      $display("FAIL wrap_end: empty=%b level=%0d, need 1 0", empty, level);
    end
  endtask

  task automatic test_overrun_clr();
    for (int i = 0; i < DEPTH; i++) cyc(1, 8'($urandom), 0, 0);
    cyc(1, 8'h11, 0, 0);
    cyc(1, 8'h22, 0, 1);
    n_tests++;
    if (ovr !== 1'b1 || level !== LW'(DEPTH)) begin
      n_fail++;
      $display("FAIL set_beats_clear: ovr=%b level=%0d, need 1 %0d", ovr, level, DEPTH);
    end
    cyc(0, 0, 0, 1);
    n_tests++;
    if (ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_alone: ovr=%b, need 0", ovr);
    end
    while (q.size() != 0) cyc(0, 0, 1, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 15) == 0));
      n_tests++;
      if (level !== LW'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == DEPTH) ||
          afull !== (q.size() >= AF) || rd_valid !== (q.size() != 0) || ovr !== m_ovr ||
          (q.size() != 0 && rd_data !== q[0])) begin
        n_fail++;
        $display("FAIL random[%0d]: level=%0d e=%b f=%b af=%b ovr=%b data=%h, need level=%0d ovr=%b data=%h",
                 i, level, empty, full, afull, ovr, rd_data, q.size(), m_ovr,
                 (q.size() != 0) ? q[0] : 8'h00);
      end
    end
`ifdef UART_RX_FIFO_STATS_EN
    n_tests++;
    if (rx_cnt !== m_rx || drop_cnt !== m_drop) begin
      n_fail++;
      $display("FAIL stats: rx=%0d drop=%0d, need %0d %0d", rx_cnt, drop_cnt, m_rx, m_drop);
    end
`endif
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) cyc(1, 8'($urandom), 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    n_tests++;
    if (empty !== 1'b1 || level !== '0 || rd_valid !== 1'b0 || ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: empty=%b level=%0d valid=%b ovr=%b, need 1 0 0 0",
               empty, level, rd_valid, ovr);
    end
`ifdef UART_RX_FIFO_STATS_EN
    n_tests++;
    if (rx_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_stats: rx=%0d drop=%0d, need 0 0", rx_cnt, drop_cnt);
    end
`endif
    @(negedge clk); rst_n = 1'b1;
    cyc(1, 8'h3C, 1, 0);
    n_tests++;
    if (level !== LW'(1) || rd_data !== 8'h3C || rd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL first_edge_write: level=%0d data=%h valid=%b, need 1 3c 1", level, rd_data, rd_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overrun();
    test_wrap();
    test_overrun_clr();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16: FIFO entries, a power of two, 4 to 256.
REQ-002 SHALL have parameter AF_THRESH, default 12: level at or above which o_almost_full asserts, 1 to DEPTH.
REQ-003 SHALL have port i_clock, input, 1 bit: the single system clock; all flops are on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port i_rx_byte, input, 8 bits: received byte from the upstream UART receiver.
REQ-006 SHALL have port i_rx_done, input, 1 bit: one-cycle strobe; i_rx_byte is valid in that cycle.
REQ-007 SHALL have port o_rd_data, output, 8 bits: oldest stored byte (show-ahead).
REQ-008 SHALL have port o_rd_valid, output, 1 bit: o_rd_data holds a stored byte.
REQ-009 SHALL have port i_rd_ready, input, 1 bit: consumer accepts o_rd_data.
REQ-010 SHALL have port o_level, output, $clog2(DEPTH)+1 bits: number of stored bytes.
REQ-011 SHALL have ports o_full, o_empty and o_almost_full, outputs, 1 bit each: status flags.
REQ-012 SHALL have port o_overrun, output, 1 bit: sticky flag, a byte was dropped.
REQ-013 SHALL have port i_clr_overrun, input, 1 bit: clears o_overrun.

Function
REQ-014 A write SHALL occur on any rising edge with i_rx_done=1 and either o_full=0 or a read in the same cycle.
REQ-015 A read SHALL occur on any rising edge with o_rd_valid=1 and i_rd_ready=1; the read pointer then advances.
REQ-016 o_rd_valid SHALL equal !o_empty, and o_rd_data SHALL equal the entry at the read pointer with no extra register stage.
REQ-017 Latency SHALL be one cycle: a byte written at edge N is visible on o_rd_data/o_rd_valid after edge N when the FIFO was empty.
REQ-018 Read and write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0 with no special case.
REQ-019 o_level SHALL go +1 on write only, -1 on read only, and stay unchanged on a simultaneous read and write.
REQ-020 When full, a simultaneous read and write SHALL both be accepted; the level stays at DEPTH and no overrun occurs.
REQ-021 When empty, with i_rx_done=1 and i_rd_ready=1, only the write SHALL occur, since no read is possible while o_rd_valid=0.
REQ-022 With i_rx_done=1, o_full=1 and no read, the byte SHALL be dropped, the FIFO left unchanged, and o_overrun set at the next edge.
REQ-023 o_overrun SHALL stay high until an edge with i_clr_overrun=1; if a drop and a clear happen in the same cycle, the set SHALL win.
REQ-024 o_full = (level == DEPTH), o_empty = (level == 0), and o_almost_full = (level >= AF_THRESH); all three SHALL derive from the registered level.
REQ-025 A read while empty SHALL be ignored and SHALL never underflow the pointers or the level.

Reset
REQ-026 While i_rst_n=0 the block SHALL asynchronously clear both pointers, the level and o_overrun; outputs then read o_empty=1, o_rd_valid=0, o_full=0, o_almost_full=0.
REQ-027 Reset asserted mid-operation SHALL discard all stored bytes; the memory array needs no reset and o_rd_data is don't-care while empty.
REQ-028 A write or read in the first edge after reset deasserts SHALL be handled normally.

Configuration
REQ-029 Macro UART_RX_FIFO_STATS_EN defined: the block SHALL add outputs o_rx_count[15:0], counting accepted writes, and o_drop_count[15:0], counting dropped bytes.
REQ-030 Both counters SHALL wrap modulo 2^16 and clear on reset.
REQ-031 Macro UART_RX_FIFO_STATS_EN undefined: the counter ports and logic SHALL be absent, and behaviour is otherwise identical.

Structure
REQ-032 Shared package uart_pkg SHALL hold UART_DATA_W=8, UART_RX_FIFO_DEPTH_DEF=16 and UART_RX_FIFO_AF_DEF=12.
REQ-033 Storage SHALL be the sub-module uart_fifo_ram: a DEPTH x 8 array with one synchronous write port and one asynchronous read port, no reset.
REQ-034 Pointer, level, flag and overrun control SHALL reside in uart_rx_fifo.

Verification
REQ-035 Reset, then strobe 0x55 with i_rd_ready=0 -> next cycle o_rd_valid=1, o_rd_data=0x55, o_level=1, o_empty=0.
REQ-036 Write 0x00..0x0F (DEPTH=16) with no reads -> o_full=1, o_almost_full asserted from level 12; a 17th strobe of 0xAA -> o_overrun=1 and the level stays 16; drain order is 0x00..0x0F (0xAA absent).
REQ-037 Full FIFO, same-cycle strobe 0x77 and read -> reads 0x00, o_level stays 16, o_overrun stays 0, and 0x77 is the last byte out.
REQ-038 Run 40 write/read pairs through DEPTH=16 -> pointers wrap twice and the data order is preserved.
REQ-039 Set o_overrun, then assert i_clr_overrun in the same cycle as a new drop -> o_overrun stays 1; clear alone -> o_overrun=0.
REQ-040 Store 5 bytes, assert i_rst_n=0 mid-stream -> immediately o_empty=1, o_level=0; with UART_RX_FIFO_STATS_EN defined, both counters read 0.
